fixed_point_divider: RTL

//  Signed two's-complement fixed-point divider/reciprocal unit: quot = (num << FRAC) / den, truncated toward zero.

---
 rtl/fixed_point_divider_if.sv | 26 ++
 rtl/fixed_point_divider.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for the signed fixed-point divider.
interface fixed_point_divider_if #(
  parameter int W = 24
) ();
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quot;
  logic         sat;
  logic         dbz;
  logic         busy;

  modport master (
    output in_valid, mode, num, den, out_ready,
    input  in_ready, out_valid, quot, sat, dbz, busy
  );

  modport slave (
    input  in_valid, mode, num, den, out_ready,
    output in_ready, out_valid, quot, sat, dbz, busy
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Signed fixed-point divide / reciprocal, radix-2 restoring,
// one quotient bit per cycle, fixed latency.
module fixed_point_divider #(
  parameter int W    = 24,
  parameter int FRAC = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fixed_point_divider_if.slave   io
);
  localparam int QW = W + FRAC;
  localparam int CW = $clog2(QW);

  localparam logic [W-1:0] ONE =
    {{(W-1-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [QW-1:0] LIM_P =
    {{(FRAC+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [QW-1:0] LIM_N =
    {{FRAC{1'b0}}, 1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, POST, DONE
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [W-1:0]  num_q, num_d;
  logic [W-1:0]  den_q, den_d;
  logic          sgn_q, sgn_d;
  logic          nneg_q, nneg_d;
  logic          dz_q, dz_d;
  logic [W-1:0]  dmag_q, dmag_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [QW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic          sat_q, sat_d;
  logic          dbz_q, dbz_d;
  logic          ov_q, ov_d;
  logic          ir_q, ir_d;
  logic          busy_q, busy_d;

  logic [W-1:0]  n_eff;
  logic [W-1:0]  n_mag;
  logic [W-1:0]  d_mag;
  logic [W:0]    rsh;
  logic [W-1:0]  trial;
  logic          ge;
  logic [W-1:0]  qlo;
  logic [W-1:0]  qneg;

  assign n_eff = mode_q ? num_q : ONE;
  assign n_mag = n_eff[W-1] ? (~n_eff + W'(1)) : n_eff;
  assign d_mag = den_q[W-1] ? (~den_q + W'(1)) : den_q;

  // Remainder is always below |den| <= 2^(W-1), so the low W bits
  // of the difference are exact whenever the subtract is kept.
  assign rsh   = {rem_q, acc_q[QW-1]};
  assign ge    = rsh >= {1'b0, dmag_q};
  assign trial = rsh[W-1:0] - dmag_q;

  assign qlo  = acc_q[W-1:0];
  assign qneg = ~qlo + W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    num_d   = num_q;
    den_d   = den_q;
    sgn_d   = sgn_q;
    nneg_d  = nneg_q;
    dz_d    = dz_q;
    dmag_d  = dmag_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    sat_d   = sat_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          mode_d  = io.mode;
          num_d   = io.num;
          den_d   = io.den;
          state_d = PREP;
        end
      end
      PREP: begin
        sgn_d   = n_eff[W-1] ^ den_q[W-1];
        nneg_d  = n_eff[W-1];
        dz_d    = (den_q == '0);
        dmag_d  = d_mag;
        rem_d   = '0;
        acc_d   = {n_mag, {FRAC{1'b0}}};
        cnt_d   = CW'(QW - 1);
        state_d = ITER;
      end
      ITER: begin
        rem_d = ge ? trial : rsh[W-1:0];
        acc_d = {acc_q[QW-2:0], ge};
        if (cnt_q == '0) begin
          state_d = POST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      POST: begin
        dbz_d = 1'b0;
        sat_d = 1'b0;
        if (dz_q) begin
          dbz_d  = 1'b1;
          quot_d = nneg_q ? MINV : MAXV;
        end else if (!sgn_q && acc_q > LIM_P) begin
          sat_d  = 1'b1;
          quot_d = MAXV;
        end else if (sgn_q && acc_q > LIM_N) begin
          sat_d  = 1'b1;
          quot_d = MINV;
        end else begin
          quot_d = sgn_q ? qneg : qlo;
        end
        state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ov_d   = (state_d == DONE);
    ir_d   = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      num_q   <= '0;
      den_q   <= '0;
      sgn_q   <= 1'b0;
      nneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      dmag_q  <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      sat_q   <= 1'b0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      den_q   <= den_d;
      sgn_q   <= sgn_d;
      nneg_q  <= nneg_d;
      dz_q    <= dz_d;
      dmag_q  <= dmag_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      sat_q   <= sat_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
      ir_q    <= ir_d;
      busy_q  <= busy_d;
    end
  end

  assign io.in_ready  = ir_q;
  assign io.out_valid = ov_q;
  assign io.quot      = quot_q;
  assign io.sat       = sat_q;
  assign io.dbz       = dbz_q;
  assign io.busy      = busy_q;
endmodule
